// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } uart_state_e;

    localparam int   DATA_BITS   = 8;
    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Even mode yields XOR of the data; odd mode yields its inverse.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic mode);
        return (^data) ^ mode;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input; reset value selectable.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, one parity bit, one stop bit; mid-bit sampling
// from a synchronized line, byte delivered as a one-cycle pulse with error flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 24000000,
    parameter int BAUD_RATE  = 8000000,
    parameter int BIT_PERIOD = CLK_FREQ / BAUD_RATE + 1,
    parameter int PARITY     = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int   HALF     = BIT_PERIOD / 2;
    localparam int   CW       = $clog2(BIT_PERIOD);
    localparam logic PAR_MODE = (PARITY != 0) ? PARITY_ODD : PARITY_EVEN;

    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_PERIOD - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

    logic rxs;
    logic fall;

    uart_state_e          state_q, state_d;
    logic [CW-1:0]        clk_count_q, clk_count_d;
    logic [2:0]           bit_index_q, bit_index_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 rx_par_q, rx_par_d;
    logic                 stop_q, stop_d;
    logic                 done_q, done_d;
    logic                 rxs_prev_q;
    logic [7:0]           rx_data_q;
    logic                 rx_valid_q, parity_err_q, frame_err_q;

    // Preset high so reset release never looks like a start edge.
    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rxs)
    );

    assign fall = rxs_prev_q & ~rxs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            clk_count_q <= '0;
            bit_index_q <= '0;
            shift_q     <= '0;
            rx_par_q    <= 1'b0;
            stop_q      <= 1'b1;
            done_q      <= 1'b0;
            rxs_prev_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            clk_count_q <= clk_count_d;
            bit_index_q <= bit_index_d;
            shift_q     <= shift_d;
            rx_par_q    <= rx_par_d;
            stop_q      <= stop_d;
            done_q      <= done_d;
            rxs_prev_q  <= rxs;
        end
    end

    always_comb begin
        state_d     = state_q;
        clk_count_d = clk_count_q + 1'b1;
        bit_index_d = bit_index_q;
        shift_d     = shift_q;
        rx_par_d    = rx_par_q;
        stop_d      = stop_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                clk_count_d = '0;
                if (fall) state_d = S_START;
            end
            S_START: begin
                if (clk_count_q == CNT_HALF) begin
                    clk_count_d = '0;
                    bit_index_d = '0;
                    state_d     = rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (clk_count_q == CNT_LAST) begin
                    clk_count_d          = '0;
                    shift_d[bit_index_q] = rxs;
                    if (bit_index_q == IDX_LAST) state_d = S_PARITY;
                    else                         bit_index_d = bit_index_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (clk_count_q == CNT_LAST) begin
                    clk_count_d = '0;
                    rx_par_d    = rxs;
                    state_d     = S_STOP;
                end
            end
            S_STOP: begin
                // Leave at mid-stop so a back-to-back start edge is not missed.
                if (clk_count_q == CNT_LAST) begin
                    clk_count_d = '0;
                    stop_d      = rxs;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                clk_count_d = '0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // Flags live only alongside the valid pulse; errored bytes are still delivered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_valid_q <= done_q;
            if (done_q) begin
                rx_data_q    <= shift_q;
                parity_err_q <= rx_par_q != parity_bit(shift_q, PAR_MODE);
                frame_err_q  <= ~stop_q;
            end else begin
                parity_err_q <= 1'b0;
                frame_err_q  <= 1'b0;
            end
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign rx_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: loopback, sweep, parity/frame errors, glitch, mid-frame reset.
module tb_uart_rx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_a = 1'b1;
    logic rx_b = 1'b1;

    logic [7:0] data_a, data_b;
    logic       vld_a, pe_a, fe_a, busy_a;
    logic       vld_b, pe_b, fe_b, busy_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cyc = 0;

    int         vcnt_a = 0;
    int         busy_cnt = 0;
    logic [7:0] log_d  [32];
    logic       log_pe [32];
    logic       log_fe [32];
    int         log_cyc[32];

    int         vcnt_b = 0;
    logic [7:0] cd_b;
    logic       cpe_b, cfe_b;

    always #5 clk = ~clk;

    uart_rx u_a (
        .clk(clk), .rst(rst), .rx(rx_a), .rx_data(data_a), .rx_valid(vld_a),
        .parity_err(pe_a), .frame_err(fe_a), .rx_busy(busy_a)
    );

    uart_rx #(.PARITY(1)) u_b (
        .clk(clk), .rst(rst), .rx(rx_b), .rx_data(data_b), .rx_valid(vld_b),
        .parity_err(pe_b), .frame_err(fe_b), .rx_busy(busy_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (vld_a && vcnt_a < 32) begin
            log_d[vcnt_a]   <= data_a;
            log_pe[vcnt_a]  <= pe_a;
            log_fe[vcnt_a]  <= fe_a;
            log_cyc[vcnt_a] <= cyc;
        end
        if (vld_a) vcnt_a <= vcnt_a + 1;
        if (busy_a) busy_cnt <= busy_cnt + 1;
        if (vld_b) begin
            vcnt_b <= vcnt_b + 1;
            cd_b   <= data_b;
            cpe_b  <= pe_b;
            cfe_b  <= fe_b;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame bits in line order: start, d0..d7, parity, stop; 4 clocks each.
    task automatic send_bits(input bit sel, input logic [10:0] f, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (i == 0) start_cyc = cyc;
            if (sel) rx_b = f[i];
            else     rx_a = f[i];
            repeat (4) @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input logic p, input logic s);
        send_bits(sel, {s, p, d, 1'b0}, 0, 10);
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [7:0] sweep_d [4];
    logic       sweep_p [4];
    logic [10:0] frame;
    int base;
    int bsnap;

    initial begin
        sweep_d[0] = 8'h00; sweep_p[0] = 1'b0;
        sweep_d[1] = 8'hFF; sweep_p[1] = 1'b0;
        sweep_d[2] = 8'h01; sweep_p[2] = 1'b1;
        sweep_d[3] = 8'h80; sweep_p[3] = 1'b1;

        settle(3);
        chk("rst_data",  {24'h0, data_a}, 32'h00);
        chk("rst_valid", {31'h0, vld_a},  32'h0);
        chk("rst_pe",    {31'h0, pe_a},   32'h0);
        chk("rst_fe",    {31'h0, fe_a},   32'h0);
        chk("rst_busy",  {31'h0, busy_a}, 32'h0);
        rst = 1'b0;
        settle(5);
        chk("idle_busy", {31'h0, busy_a}, 32'h0);

        // Loopback 0xA5, even parity bit 0
        base = vcnt_a;
        send(0, 8'hA5, 1'b0, 1'b1);
        settle(4);
        chk("lb_count", vcnt_a, base + 1);
        chk("lb_data",  {24'h0, log_d[base]}, 32'hA5);
        chk("lb_pe",    {31'h0, log_pe[base]}, 32'h0);
        chk("lb_fe",    {31'h0, log_fe[base]}, 32'h0);
        chk("lb_lat",   {31'h0, ((log_cyc[base] - start_cyc) >= 45) && ((log_cyc[base] - start_cyc) <= 47)}, 32'h1);
        chk("lb_hold",  {24'h0, data_a}, 32'hA5);

        // Back-to-back sweep
        base = vcnt_a;
        for (int i = 0; i < 4; i++) send(0, sweep_d[i], sweep_p[i], 1'b1);
        settle(4);
        chk("sw_count", vcnt_a, base + 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("sw_data%0d", i), {24'h0, log_d[base+i]}, {24'h0, sweep_d[i]});
            chk($sformatf("sw_err%0d", i), {31'h0, log_pe[base+i] | log_fe[base+i]}, 32'h0);
        end

        // Parity error, even mode: 0x01 with parity bit 0
        base = vcnt_a;
        send(0, 8'h01, 1'b0, 1'b1);
        settle(4);
        chk("pe_count", vcnt_a, base + 1);
        chk("pe_data",  {24'h0, log_d[base]}, 32'h01);
        chk("pe_pe",    {31'h0, log_pe[base]}, 32'h1);
        chk("pe_fe",    {31'h0, log_fe[base]}, 32'h0);
        chk("pe_clear", {31'h0, pe_a}, 32'h0);

        // Parity error, odd mode: 0x01 with parity bit 1
        base = vcnt_b;
        send(1, 8'h01, 1'b1, 1'b1);
        settle(4);
        chk("po_count", vcnt_b, base + 1);
        chk("po_data",  {24'h0, cd_b}, 32'h01);
        chk("po_pe",    {31'h0, cpe_b}, 32'h1);
        chk("po_fe",    {31'h0, cfe_b}, 32'h0);

        // Frame error: 0x3C with stop low, line stuck low 20 clocks
        base = vcnt_a;
        send(0, 8'h3C, 1'b0, 1'b0);
        settle(20);
        rx_a = 1'b1;
        chk("fe_count", vcnt_a, base + 1);
        chk("fe_data",  {24'h0, log_d[base]}, 32'h3C);
        chk("fe_fe",    {31'h0, log_fe[base]}, 32'h1);
        chk("fe_pe",    {31'h0, log_pe[base]}, 32'h0);
        settle(20);
        chk("fe_nomore", vcnt_a, base + 1);
        chk("fe_busy",   {31'h0, busy_a}, 32'h0);

        // One-clock glitch, then a clean 0x5A
        base  = vcnt_a;
        bsnap = busy_cnt;
        rx_a  = 1'b0;
        settle(1);
        rx_a  = 1'b1;
        settle(12);
        chk("gl_busy_seen", {31'h0, busy_cnt > bsnap}, 32'h1);
        chk("gl_novalid",   vcnt_a, base);
        chk("gl_idle",      {31'h0, busy_a}, 32'h0);
        send(0, 8'h5A, 1'b0, 1'b1);
        settle(4);
        chk("gl_count", vcnt_a, base + 1);
        chk("gl_data",  {24'h0, log_d[base]}, 32'h5A);
        chk("gl_err",   {31'h0, log_pe[base] | log_fe[base]}, 32'h0);

        // Reset during data bit 4 of 0xC3, held to end of frame
        base  = vcnt_a;
        frame = {1'b1, 1'b0, 8'hC3, 1'b0};
        send_bits(0, frame, 0, 4);
        rx_a = frame[5];
        settle(2);
        chk("mr_busy_before", {31'h0, busy_a}, 32'h1);
        rst = 1'b1;
        #1;
        chk("mr_data",  {24'h0, data_a}, 32'h00);
        chk("mr_busy",  {31'h0, busy_a}, 32'h0);
        chk("mr_valid", {31'h0, vld_a},  32'h0);
        settle(2);
        send_bits(0, frame, 6, 10);
        rst = 1'b0;
        settle(5);
        chk("mr_novalid", vcnt_a, base);
        send(0, 8'h96, 1'b0, 1'b1);
        settle(4);
        chk("mr_count", vcnt_a, base + 1);
        chk("mr_next",  {24'h0, log_d[base]}, 32'h96);
        chk("mr_err",   {31'h0, log_pe[base] | log_fe[base]}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
